// File: rtl/alarm_pkg.sv
// Shared encodings and defaults for the alarm bank: controller states, slot modes,
// the packed alarm time record and the time comparator used by every slot.
package alarm_pkg;

  localparam int DEF_NUM_ALARMS       = 4;
  localparam int DEF_SNOOZE_SEC       = 300;
  localparam int DEF_RING_TIMEOUT_SEC = 60;
  localparam int CNT_W                = 12;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZED = 2'd2;

  localparam logic MODE_ONCE  = 1'b0;
  localparam logic MODE_DAILY = 1'b1;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
  } alarm_time_t;

  // Daily alarms only look at hh:mm:ss; once alarms need the full date to agree.
  function automatic logic time_hit(input alarm_time_t stored, input logic mode,
                                    input logic [55:0] now);
    if (mode == MODE_DAILY)
      return now[23:0] == {stored.hour, stored.minute, stored.second};
    return now == stored;
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: programmed time, enable and mode, plus the per-second match strobe.
// A disable request beats a simultaneous program request and leaves the old time intact.
module alarm_slot
  import alarm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        dis_en,
  input  logic        expire_en,
  input  alarm_time_t time_in,
  input  logic        mode_in,
  input  logic [55:0] now,
  input  logic        sec_tick,
  output logic [23:0] hms,
  output logic        enabled,
  output logic        mode,
  output logic        match
);

  alarm_time_t time_reg;
  logic        enabled_reg;
  logic        mode_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_reg    <= '0;
      enabled_reg <= 1'b0;
      mode_reg    <= MODE_ONCE;
    end else if (dis_en) begin
      enabled_reg <= 1'b0;
    end else if (wr_en) begin
      time_reg    <= time_in;
      mode_reg    <= mode_in;
      enabled_reg <= 1'b1;
    end else if (expire_en) begin
      // a once alarm that has been served retires itself
      enabled_reg <= 1'b0;
    end
  end

  assign hms     = {time_reg.hour, time_reg.minute, time_reg.second};
  assign enabled = enabled_reg;
  assign mode    = mode_reg;
  assign match   = sec_tick && enabled_reg && time_hit(time_reg, mode_reg, now);

endmodule

// File: rtl/alarm_bank.sv
// Bank of alarm slots with a shared ring/snooze controller that serves pending
// alarms one at a time, lowest slot index first.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS       = DEF_NUM_ALARMS,
  parameter int SNOOZE_SEC       = DEF_SNOOZE_SEC,
  parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          set,
  input  logic                          disable_slot,
  input  logic [15:0]                   alarm_year_bcd_in,
  input  logic [7:0]                    alarm_month_bcd_in,
  input  logic [7:0]                    alarm_day_bcd_in,
  input  logic [7:0]                    alarm_hour_bcd_in,
  input  logic [7:0]                    alarm_minute_bcd_in,
  input  logic [7:0]                    alarm_second_bcd_in,
  input  logic                          mode_in,
  input  logic [$clog2(NUM_ALARMS)-1:0] sel,
  input  logic [63:0]                   counter,
  input  logic                          sec_tick,
  input  logic                          cancel,
  input  logic                          snooze,
  output logic [7:0]                    alarm_hour_bcd,
  output logic [7:0]                    alarm_minute_bcd,
  output logic [7:0]                    alarm_second_bcd,
  output logic                          rd_enabled,
  output logic                          rd_mode,
  output logic                          ring,
  output logic [$clog2(NUM_ALARMS)-1:0] ring_id,
  output logic [NUM_ALARMS-1:0]         pending
);

  localparam int SEL_W = $clog2(NUM_ALARMS);
  localparam int RB_N  = 1 << SEL_W;
  localparam logic [CNT_W-1:0] SNZ_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(RING_TIMEOUT_SEC);

  logic [1:0]            state_reg, state_next;
  logic [SEL_W-1:0]      ring_id_reg, ring_id_next;
  logic [CNT_W-1:0]      tmo_reg, tmo_next;
  logic [CNT_W-1:0]      snz_reg, snz_next;
  logic [NUM_ALARMS-1:0] pending_reg, pending_next;

  alarm_time_t           set_time;
  logic [NUM_ALARMS-1:0] match_vec;
  logic [NUM_ALARMS-1:0] cfg_hit_vec;
  logic [NUM_ALARMS-1:0] expire_vec;
  logic [NUM_ALARMS-1:0] ring_onehot;
  logic [NUM_ALARMS-1:0] absorb_vec;
  logic [NUM_ALARMS-1:0] clr_vec;
  logic [NUM_ALARMS-1:0] pend_avail;
  logic [SEL_W-1:0]      first_id;
  logic                  cfg_on_ring;
  logic                  svc_end;
  logic                  svc_abort;
  logic                  unused_counter_hi;

  logic [23:0]           rb_hms [RB_N];
  logic [RB_N-1:0]       rb_en;
  logic [RB_N-1:0]       rb_mode;

  assign set_time = {alarm_year_bcd_in, alarm_month_bcd_in, alarm_day_bcd_in,
                     alarm_hour_bcd_in, alarm_minute_bcd_in, alarm_second_bcd_in};
  assign unused_counter_hi = ^counter[63:56];

  assign ring_onehot = {{(NUM_ALARMS-1){1'b0}}, 1'b1} << ring_id_reg;
  assign cfg_on_ring = |(cfg_hit_vec & ring_onehot);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
      assign cfg_hit_vec[gi] = (set || disable_slot) && (sel == SEL_W'(gi));
      assign expire_vec[gi]  = svc_end && ring_onehot[gi] && (rb_mode[gi] == MODE_ONCE);

      alarm_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (set && (sel == SEL_W'(gi))),
        .dis_en    (disable_slot && (sel == SEL_W'(gi))),
        .expire_en (expire_vec[gi]),
        .time_in   (set_time),
        .mode_in   (mode_in),
        .now       (counter[55:0]),
        .sec_tick  (sec_tick),
        .hms       (rb_hms[gi]),
        .enabled   (rb_en[gi]),
        .mode      (rb_mode[gi]),
        .match     (match_vec[gi])
      );
    end
    // Unpopulated select codes read back as an empty, disabled slot.
    for (gi = NUM_ALARMS; gi < RB_N; gi++) begin : g_pad
      assign rb_hms[gi]  = '0;
      assign rb_en[gi]   = 1'b0;
      assign rb_mode[gi] = MODE_ONCE;
    end
  endgenerate

  assign alarm_hour_bcd   = rb_hms[sel][23:16];
  assign alarm_minute_bcd = rb_hms[sel][15:8];
  assign alarm_second_bcd = rb_hms[sel][7:0];
  assign rd_enabled       = rb_en[sel];
  assign rd_mode          = rb_mode[sel];

  // Reprogramming a slot drops whatever it had queued, so it cannot win arbitration.
  assign pend_avail = pending_reg & ~cfg_hit_vec;

  always_comb begin
    first_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pend_avail[i]) first_id = SEL_W'(i);
    end
  end

  always_comb begin
    state_next   = state_reg;
    ring_id_next = ring_id_reg;
    tmo_next     = tmo_reg;
    snz_next     = snz_reg;
    svc_end      = 1'b0;
    svc_abort    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|pend_avail) begin
          state_next   = ST_RINGING;
          ring_id_next = first_id;
          tmo_next     = TMO_LOAD;
        end
      end
      ST_RINGING: begin
        if (cancel) begin
          svc_end    = 1'b1;
          state_next = ST_IDLE;
        end else if (cfg_on_ring) begin
          svc_abort  = 1'b1;
          state_next = ST_IDLE;
        end else if (snooze) begin
          state_next = ST_SNOOZED;
          snz_next   = SNZ_LOAD;
        end else if (sec_tick) begin
          if (tmo_reg <= CNT_W'(1)) begin
            svc_end    = 1'b1;
            state_next = ST_IDLE;
          end
          tmo_next = (tmo_reg == '0) ? '0 : tmo_reg - CNT_W'(1);
        end
      end
      ST_SNOOZED: begin
        if (cancel) begin
          svc_end    = 1'b1;
          state_next = ST_IDLE;
        end else if (cfg_on_ring) begin
          svc_abort  = 1'b1;
          state_next = ST_IDLE;
        end else if (sec_tick) begin
          if (snz_reg <= CNT_W'(1)) begin
            state_next = ST_RINGING;
            tmo_next   = TMO_LOAD;
          end
          snz_next = (snz_reg == '0) ? '0 : snz_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // While a slot is being served, its own re-matches are swallowed rather than queued.
  assign absorb_vec   = (state_reg != ST_IDLE) ? ring_onehot : '0;
  assign clr_vec      = cfg_hit_vec | ((svc_end || svc_abort) ? ring_onehot : '0);
  assign pending_next = (pending_reg | (match_vec & ~absorb_vec)) & ~clr_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ring_id_reg <= '0;
      tmo_reg     <= '0;
      snz_reg     <= '0;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ring_id_reg <= ring_id_next;
      tmo_reg     <= tmo_next;
      snz_reg     <= snz_next;
      pending_reg <= pending_next;
    end
  end

  assign ring    = (state_reg == ST_RINGING);
  assign ring_id = ring_id_reg;
  assign pending = pending_reg;

endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4, number of alarm slots (2..16).
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, snooze length in seconds (1..4095).
REQ-003 SHALL have parameter RING_TIMEOUT_SEC, default 60, auto-stop length in seconds (1..4095).
REQ-004 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port set  in  1  one-cycle pulse, program slot sel with *_bcd_in and mode_in, enable it.
REQ-007 SHALL have port disable_slot  in  1  one-cycle pulse, disable slot sel.
REQ-008 SHALL have ports alarm_year_bcd_in 16, alarm_month/day/hour/minute/second_bcd_in 8 each  in  programmed time.
REQ-009 SHALL have port mode_in  in  1  0=once, 1=daily.
REQ-010 SHALL have port sel  in  clog2(NUM_ALARMS)  slot for set/disable/read-back.
REQ-011 SHALL have port counter  in  64  current time {8'h0, year16, month8, day8, hour8, minute8, second8} BCD.
REQ-012 SHALL have port sec_tick  in  1  one-cycle pulse per second; counter is valid on that cycle.
REQ-013 SHALL have ports cancel, snooze  in  1 each  one-cycle user pulses.
REQ-014 SHALL have ports alarm_hour_bcd, alarm_minute_bcd, alarm_second_bcd  out  8 each  stored time of slot sel.
REQ-015 SHALL have ports rd_enabled, rd_mode  out  1 each  enable and mode of slot sel.
REQ-016 SHALL have ports ring  out 1; ring_id  out clog2(NUM_ALARMS); pending  out NUM_ALARMS.

Function
REQ-017 Read-back outputs SHALL be combinational from slot sel storage.
REQ-018 On a cycle with sec_tick=1, each enabled slot SHALL match if counter[55:0] equals stored time (once) or counter[23:0] equals stored hh:mm:ss (daily); matching slots set pending bit at that edge.
REQ-019 Without sec_tick, no match SHALL be evaluated; pending bits persist until served.
REQ-020 Controller SHALL be FSM IDLE/RINGING/SNOOZED; ring=1 only in RINGING.
REQ-021 IDLE with pending!=0 SHALL go RINGING next edge, ring_id = lowest pending index; match at edge k gives ring=1 after edge k+1.
REQ-022 RINGING SHALL count sec_ticks; at RING_TIMEOUT_SEC-th tick -> IDLE, service ends.
REQ-023 RINGING + snooze SHALL -> SNOOZED, load SNOOZE_SEC; each sec_tick decrements; at zero -> RINGING, same ring_id, timeout counter reloaded.
REQ-024 cancel in RINGING or SNOOZED SHALL -> IDLE, service ends; cancel in IDLE ignored.
REQ-025 Service end SHALL clear pending[ring_id]; once-mode slot SHALL also be disabled; daily slot stays enabled.
REQ-026 cancel and snooze same cycle: cancel SHALL win.
REQ-027 Matches of other slots during RINGING/SNOOZED SHALL queue in pending and be served in index order afterward; re-match of the slot being served SHALL be absorbed.
REQ-028 set or disable_slot on slot == ring_id while RINGING/SNOOZED SHALL abort to IDLE and clear that pending bit; on other slots SHALL clear that slot's pending bit only.
REQ-029 set and disable_slot same cycle: disable SHALL win; slot stays unprogrammed-enable-off with new data not written.
REQ-030 Timeout/snooze counters SHALL be 12-bit, saturating at zero.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, ring=0, ring_id=0, pending=0, all slots disabled, mode 0, stored times 0, counters 0; read-back outputs therefore 0.
REQ-032 Reset mid-ring SHALL drop ring asynchronously; no service resumes after release.

Structure
REQ-033 Package alarm_pkg SHALL hold FSM state encodings, mode codes (ONCE, DAILY) and default parameter values.
REQ-034 Sub-module alarm_slot (storage, enable, mode, comparator, match output) SHALL be instantiated NUM_ALARMS times via generate; FSM, arbitration and counters live in alarm_bank.

Verification
REQ-035 Program slot 0 once 2023-12-31 23:59:59, drive that counter with sec_tick -> ring=1 two edges later, ring_id=0; cancel -> ring=0, rd_enabled(slot0)=0.
REQ-036 Slot 1 daily 07:00:00; tick at 2024-01-01 07:00:00 then 2024-01-02 07:00:00 with cancels between -> ring twice, slot stays enabled.
REQ-037 SNOOZE_SEC=3: ring, snooze -> ring=0; third sec_tick -> ring=1, same ring_id.
REQ-038 RING_TIMEOUT_SEC=5, no cancel -> ring drops after 5th sec_tick, pending bit cleared.
REQ-039 Slots 2 and 3 same time -> ring_id=2; cancel -> ring_id=3 next cycle; cancel+snooze same cycle -> IDLE.
REQ-040 Assert rst_n=0 while RINGING -> ring=0 immediately, pending=0, all rd_enabled=0.
